fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Upstream neighbour of the instruction decoder in picoMips. Owns the program counter, the 3-phase stage counter and the instruction register. It also synchronises the external handshake switch. It drives the decoder's Instruction, Stage and Handshake inputs, addresses the program ROM, and consumes the decoder's PCHold to stall on wait-for-handshake instructions.

Parameters:
PC_WIDTH, 8, program counter / ROM address width
INSTR_WIDTH, 12, instruction word width
PROG_LEN, 256, number of valid ROM words; PC wraps to 0 after PROG_LEN-1 (2 <= PROG_LEN <= 2**PC_WIDTH)
SYNC_STAGES, 2, flip-flops in handshake synchroniser (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
HandshakeIn  input  1  raw asynchronous handshake switch
PCHold  input  1  from decoder; stall request, sampled only in stage EXEC_WB
RomData  input  INSTR_WIDTH  combinational ROM read data for RomAddr, valid same cycle
RomAddr  output  PC_WIDTH  ROM address, equals PC (combinational from PC register)
Instruction  output  INSTR_WIDTH  instruction register to decoder
Stage  output  2  current stage to decoder
Handshake  output  1  synchronised handshake to decoder
PC  output  PC_WIDTH  current program counter (debug/LEDs)

Behaviour:
- Reset (async assert, sync release): PC=0, Stage=FETCH(2'b00), Instruction=0, all sync flops=0, so Handshake=0. Instruction=0 decodes as a no-op with no register write. Reset mid-stall or mid-instruction aborts immediately; no partial write.
- Stage FSM, advanced every clk: FETCH(00) -> DECODE(01) -> EXEC_WB(10) -> FETCH. Encoding 2'b11 is illegal; if reached, next state is FETCH with PC, Instruction unchanged.
- FETCH: at the end-of-cycle edge, Instruction <= RomData (read at address PC). Instruction is otherwise held and is stable through DECODE and EXEC_WB.
- DECODE: no state change besides Stage.
- EXEC_WB, PCHold=0: next Stage=FETCH. PC <= PC+1, or PC <= 0 if PC == PROG_LEN-1.
- EXEC_WB, PCHold=1: Stage stays EXEC_WB. PC and Instruction are held. PCHold is re-sampled every cycle; the cycle after it drops, the normal advance occurs. There is no stall limit.
- PCHold is ignored in FETCH and DECODE.
- Nominal throughput: 3 cycles per instruction. A stall adds N cycles, where N is the number of consecutive cycles PCHold=1 in EXEC_WB.
- Synchroniser: HandshakeIn shifts through SYNC_STAGES flops each clk. Handshake = last flop. Latency from a stable change to the output change is SYNC_STAGES edges. It is independent of Stage and PCHold.
- Simultaneous PCHold release and handshake change: PCHold is computed from the already-synchronised Handshake, so there is no ordering hazard inside this block.
- Wrap-around: PC == PROG_LEN-1 with no hold gives PC=0 in the next FETCH. A hold at PROG_LEN-1 keeps PC at PROG_LEN-1.
- RomAddr is driven only from the PC register, so there is no combinational path from PCHold or RomData to RomAddr.

Decomposition:
- Shared package picomips_pkg: stage_t enum {FETCH=2'b00, DECODE=2'b01, EXEC_WB=2'b10}; INSTR_WIDTH constant shared with the decoder.
- One sub-module: sync_chain (parameter SYNC_STAGES, async active-high reset to 0) holding the handshake synchroniser. The FSM, PC and instruction register stay in fetch_sequencer.

Test Plan:
1. Reset, then release with ROM[0]=12'hA5C, ROM[1]=12'h3F1 -> Stage 00,01,10,00,... ; Instruction=12'hA5C from the 2nd cycle; PC=1 at the 4th cycle; Instruction=12'h3F1 at the 5th cycle.
2. Hold PCHold=1 for 5 cycles in EXEC_WB at PC=7 -> Stage stays 10 for 6 cycles total, PC=7, Instruction unchanged; release -> next cycle Stage=00, PC=8.
3. PROG_LEN=16, run to PC=15, PCHold=0 -> next FETCH has PC=0, RomAddr=0.
4. Toggle HandshakeIn 0->1 mid-cycle with SYNC_STAGES=2 -> Handshake rises exactly 2 rising edges later; a 1->0 change gives the same latency.
5. Assert reset during a stall (Stage=10, PC=0x42) -> immediately PC=0, Stage=00, Instruction=0, Handshake=0; normal fetch of ROM[0] after release.
6. PCHold=1 driven during FETCH and DECODE only -> no effect; PC advances normally after EXEC_WB.

Source files
------------

// File: rtl/picomips_pkg.sv
// Types and constants shared between the picoMips fetch sequencer and the decoder.
package picomips_pkg;

   localparam int INSTR_WIDTH = 12;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      DECODE  = 2'b01,
      EXEC_WB = 2'b10
   } stage_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for the raw handshake switch; output is the last flop.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   output logic dout_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   assign dout_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fetch_sequencer.sv
// picoMips fetch sequencer: PC, 3-phase stage counter, instruction register and
// handshake synchroniser feeding the decoder.
module fetch_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = picomips_pkg::INSTR_WIDTH,
   parameter int PROG_LEN    = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   HandshakeIn,
   input  logic                   PCHold,
   input  logic [INSTR_WIDTH-1:0] RomData,
   output logic [PC_WIDTH-1:0]    RomAddr,
   output logic [INSTR_WIDTH-1:0] Instruction,
   output logic [1:0]             Stage,
   output logic                   Handshake,
   output logic [PC_WIDTH-1:0]    PC
);
   import picomips_pkg::*;

   localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

   stage_t                 stage_q, stage_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= FETCH;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         stage_q <= stage_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // The illegal 2'b11 encoding falls into default and recovers to FETCH.
   always_comb begin
      stage_d = FETCH;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (stage_q)
         FETCH: begin
            stage_d = DECODE;
            instr_d = RomData;
         end
         DECODE: begin
            stage_d = EXEC_WB;
         end
         EXEC_WB: begin
            if (PCHold) begin
               stage_d = EXEC_WB;
            end else begin
               stage_d = FETCH;
               pc_d    = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
            end
         end
         default: begin
            stage_d = FETCH;
         end
      endcase
   end

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din_i (HandshakeIn),
      .dout_o(Handshake)
   );

   assign RomAddr     = pc_q;
   assign PC          = pc_q;
   assign Instruction = instr_q;
   assign Stage       = stage_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a full-size instance plus a PROG_LEN=16
// instance sharing the same stimulus, compared against a cycle model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        HandshakeIn = 1'b0;
   logic        PCHold = 1'b0;
   logic [11:0] rom [256];

   logic [11:0] RomData, RomData16;
   logic [7:0]  RomAddr, PC;
   logic [11:0] Instruction;
   logic [1:0]  Stage;
   logic        Handshake;
   logic [3:0]  RomAddr16, PC16;
   logic [11:0] Instruction16;
   logic [1:0]  Stage16;
   logic        Handshake16;

   always #5 clk = ~clk;

   assign RomData   = rom[RomAddr];
   assign RomData16 = rom[{4'd0, RomAddr16}];

   fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(12), .PROG_LEN(256), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .HandshakeIn(HandshakeIn), .PCHold(PCHold),
      .RomData(RomData), .RomAddr(RomAddr), .Instruction(Instruction),
      .Stage(Stage), .Handshake(Handshake), .PC(PC)
   );

   fetch_sequencer #(.PC_WIDTH(4), .INSTR_WIDTH(12), .PROG_LEN(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .reset(reset), .HandshakeIn(HandshakeIn), .PCHold(PCHold),
      .RomData(RomData16), .RomAddr(RomAddr16), .Instruction(Instruction16),
      .Stage(Stage16), .Handshake(Handshake16), .PC(PC16)
   );

   typedef logic [40:0] obs_t;
   obs_t obs;
   assign obs = {Stage, PC, Instruction, Handshake, RomAddr, Stage16, PC16, RomAddr16};

   obs_t        sbQ [$];
   int          checks = 0;
   int          failures = 0;
   logic        curHs = 1'b0;

   logic [1:0]  mStage;
   logic [7:0]  mPc;
   logic [11:0] mInstr;
   logic [1:0]  mSync;
   logic [3:0]  mPc16;

   task automatic modelReset();
      mStage = 2'b00;
      mPc    = 8'd0;
      mInstr = 12'd0;
      mSync  = 2'b00;
      mPc16  = 4'd0;
      sbQ.delete();
   endtask

   // Drives one cycle's inputs (at a falling edge) and pushes the expected post-edge state.
   task automatic driveCycle(input logic hold, input logic hs);
      PCHold      = hold;
      HandshakeIn = hs;
      case (mStage)
         2'b00: begin
            mInstr = rom[mPc];
            mStage = 2'b01;
         end
         2'b01: mStage = 2'b10;
         default: begin
            if (!hold) begin
               mStage = 2'b00;
               mPc    = (mPc == 8'd255) ? 8'd0 : mPc + 8'd1;
               mPc16  = (mPc16 == 4'd15) ? 4'd0 : mPc16 + 4'd1;
            end
         end
      endcase
      mSync = {mSync[0], hs};
      sbQ.push_back({mStage, mPc, mInstr, mSync[1], mPc, mStage, mPc16, mPc16});
   endtask

   task automatic test_reset();
      obs_t exp;
      reset = 1'b1;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp = '0;
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL reset_state got=%h want=%h", obs, exp);
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch_order();
      obs_t exp;
      for (int c = 1; c <= 5; c++) begin
         driveCycle(1'b0, curHs);
         @(posedge clk);
         @(negedge clk);
         exp = sbQ.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL fetch_order_sb cycle=%0d got=%h want=%h", c, obs, exp);
         end
         if (c == 1) begin
            checks++;
            if (Stage !== 2'b01 || Instruction !== 12'hA5C) begin
               failures++;
               $display("[TB] FAIL fetch_first_instr stage=%b instr=%h want 01/a5c", Stage, Instruction);
            end
         end
         if (c == 3) begin
            checks++;
            if (Stage !== 2'b00 || PC !== 8'd1) begin
               failures++;
               $display("[TB] FAIL fetch_pc_advance stage=%b pc=%h want 00/01", Stage, PC);
            end
         end
         if (c == 4) begin
            checks++;
            if (Instruction !== 12'h3F1) begin
               failures++;
               $display("[TB] FAIL fetch_second_instr got=%h want=3f1", Instruction);
            end
         end
      end
   endtask

   // Free-runs with no hold until the model reaches the requested PC/stage.
   task automatic runTo(input int wantPc, input bit use16, input logic [1:0] wantStage);
      obs_t exp;
      int   n;
      n = 0;
      while (!((wantPc < 0 || (use16 ? int'(mPc16) : int'(mPc)) == wantPc) && mStage == wantStage)
             && n < 1000) begin
         driveCycle(1'b0, curHs);
         @(posedge clk);
         @(negedge clk);
         exp = sbQ.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL run_sb got=%h want=%h", obs, exp);
         end
         n++;
      end
      if (n >= 1000) begin
         checks++;
         failures++;
         $display("[TB] FAIL run_timeout pc=%0d want=%0d", mPc, wantPc);
      end
   endtask

   task automatic test_stall();
      obs_t exp;
      runTo(7, 1'b0, 2'b10);
      for (int c = 0; c < 6; c++) begin
         driveCycle(c < 5, curHs);
         @(posedge clk);
         @(negedge clk);
         exp = sbQ.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL stall_sb cycle=%0d got=%h want=%h", c, obs, exp);
         end
         checks++;
         if (c < 5 && (Stage !== 2'b10 || PC !== 8'd7 || Instruction !== rom[7])) begin
            failures++;
            $display("[TB] FAIL stall_hold stage=%b pc=%h instr=%h want 10/07/%h", Stage, PC, Instruction, rom[7]);
         end else if (c == 5 && (Stage !== 2'b00 || PC !== 8'd8)) begin
            failures++;
            $display("[TB] FAIL stall_release stage=%b pc=%h want 00/08", Stage, PC);
         end
      end
   endtask

   task automatic test_wrap();
      obs_t exp;
      runTo(15, 1'b1, 2'b10);
      driveCycle(1'b0, curHs);
      @(posedge clk);
      @(negedge clk);
      exp = sbQ.pop_front();
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL wrap_sb got=%h want=%h", obs, exp);
      end
      checks++;
      if (PC16 !== 4'd0 || RomAddr16 !== 4'd0 || Stage16 !== 2'b00) begin
         failures++;
         $display("[TB] FAIL wrap_pc pc=%h addr=%h stage=%b want 0/0/00", PC16, RomAddr16, Stage16);
      end
   endtask

   task automatic test_handshake();
      obs_t exp;
      logic lvl;
      for (int t = 0; t < 2; t++) begin
         lvl   = (t == 0);
         curHs = lvl;
         for (int c = 1; c <= 3; c++) begin
            driveCycle(1'b0, curHs);
            @(posedge clk);
            @(negedge clk);
            exp = sbQ.pop_front();
            checks++;
            if (obs !== exp) begin
               failures++;
               $display("[TB] FAIL hs_sb level=%b cycle=%0d got=%h want=%h", lvl, c, obs, exp);
            end
            checks++;
            if (Handshake !== ((c >= 2) ? lvl : ~lvl)) begin
               failures++;
               $display("[TB] FAIL hs_latency level=%b edge=%0d got=%b", lvl, c, Handshake);
            end
         end
      end
   endtask

   task automatic test_reset_in_stall();
      obs_t exp;
      curHs = 1'b1;
      runTo(8'h42, 1'b0, 2'b10);
      for (int c = 0; c < 2; c++) begin
         driveCycle(1'b1, curHs);
         @(posedge clk);
         @(negedge clk);
         exp = sbQ.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL pre_reset_stall_sb got=%h want=%h", obs, exp);
         end
      end
      reset = 1'b1;
      #1;
      exp = '0;
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL reset_in_stall got=%h want=%h", obs, exp);
      end
      modelReset();
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      curHs  = 1'b0;
      driveCycle(1'b0, curHs);
      @(posedge clk);
      @(negedge clk);
      exp = sbQ.pop_front();
      checks++;
      if (obs !== exp || Instruction !== 12'hA5C) begin
         failures++;
         $display("[TB] FAIL post_reset_fetch got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_hold_ignored();
      obs_t       exp;
      logic [7:0] startPc;
      runTo(-1, 1'b0, 2'b00);
      startPc = mPc;
      for (int c = 0; c < 3; c++) begin
         driveCycle(c < 2, curHs);
         @(posedge clk);
         @(negedge clk);
         exp = sbQ.pop_front();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL hold_ignored_sb cycle=%0d got=%h want=%h", c, obs, exp);
         end
      end
      checks++;
      if (Stage !== 2'b00 || PC !== startPc + 8'd1) begin
         failures++;
         $display("[TB] FAIL hold_ignored_pc stage=%b pc=%h want 00/%h", Stage, PC, startPc + 8'd1);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 12'($urandom_range(1, 4095));
      rom[0] = 12'hA5C;
      rom[1] = 12'h3F1;
      test_reset();
      test_fetch_order();
      test_stall();
      test_wrap();
      test_handshake();
      test_reset_in_stall();
      test_hold_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
